alu_seq_ctrl: RTL and testbench

//  Sequencer in front of the 16-bit ALU16b datapath: accepts one command via valid/ready, drives the ALU inputs, returns a registered result/flags.

---
 rtl/alu_seq_ctrl_pkg.sv | 45 ++++
 rtl/alu_seq_ctrl_mulstep.sv | 34 +++
 rtl/alu_seq_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: command encodings, ALU op codes,
// FSM state encoding and the datapath width.
package alu_seq_ctrl_pkg;

  localparam int unsigned DATA_W = 16;

  // Command encodings seen on req_cmd. Codes 0-5 map one-to-one onto ALU ops.
  typedef enum logic [2:0] {
    CMD_AND = 3'b000,
    CMD_OR  = 3'b001,
    CMD_NOR = 3'b010,
    CMD_ADD = 3'b011,
    CMD_SUB = 3'b100,
    CMD_SLT = 3'b101,
    CMD_MUL = 3'b110,
    CMD_ILL = 3'b111
  } cmd_e;

  // ALU16b op codes.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_NOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True for commands that complete in a single ALU cycle.
  function automatic logic is_alu_cmd(input logic [2:0] cmd);
    logic res;
    case (cmd)
      CMD_AND, CMD_OR, CMD_NOR, CMD_ADD, CMD_SUB, CMD_SLT: res = 1'b1;
      default:                                             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_mulstep.sv
// One shift-add multiply step. The ALU has already formed hi + multiplicand
// on alu_r; this picks either that sum or hi depending on the current
// multiplier bit, recovers the carry out of the 16-bit add, and shifts the
// {carry, sum, lo} chain right by one.
module alu_seq_ctrl_mulstep
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] alu_r_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] sum_s;
  logic             c_s;

  // Select sum and carry; an unsigned wrap of hi + a shows up as r < hi.
  always_comb begin
    sum_s = hi_i;
    c_s   = 1'b0;
    if (lo_i[0]) begin
      sum_s = alu_r_i;
      c_s   = (alu_r_i < hi_i);
    end else begin
      sum_s = hi_i;
      c_s   = 1'b0;
    end
    {hi_o, lo_o} = {c_s, sum_s, lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of ALU16b. Accepts one command at a time,
// drives the ALU operand/op inputs, runs 16-step shift-add multiplies on the
// ALU adder, and holds a registered result until the consumer takes it.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_ovfl,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             res_zero,
  output logic             res_ovfl,
  output logic             res_err
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [2:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             res_zero_q, res_zero_d;
  logic             res_ovfl_q, res_ovfl_d;
  logic             res_err_q, res_err_d;

  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [2:0]       alu_op_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic             accept_s;

  alu_seq_ctrl_mulstep #(
    .WIDTH (WIDTH)
  ) u_mulstep (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .alu_r_i (alu_r),
    .hi_o    (step_hi_s),
    .lo_o    (step_lo_s)
  );

  // rdy_q mirrors "state is IDLE" but stays low for the first cycle after
  // reset, so the block never advertises ready while reset is asserted.
  assign accept_s  = req_valid && rdy_q && !flush;
  assign req_ready = rdy_q && !flush;

  // Next-state, datapath updates and ALU drive for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    a_d          = a_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    res_lo_d     = res_lo_q;
    res_hi_d     = res_hi_q;
    res_zero_d   = res_zero_q;
    res_ovfl_d   = res_ovfl_q;
    res_err_d    = res_err_q;
    alu_a_s      = {WIDTH{1'b0}};
    alu_b_s      = {WIDTH{1'b0}};
    alu_op_s     = 3'b000;

    if (flush) begin
      // Abort: drop whatever is in flight and clear the response.
      state_d      = ST_IDLE;
      resp_valid_d = 1'b0;
      res_lo_d     = {WIDTH{1'b0}};
      res_hi_d     = {WIDTH{1'b0}};
      res_zero_d   = 1'b0;
      res_ovfl_d   = 1'b0;
      res_err_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_d = req_cmd;
            a_d   = req_a;
            b_d   = req_b;
            if (is_alu_cmd(req_cmd)) begin
              state_d = ST_EXEC;
            end else if ((req_cmd == CMD_MUL) && MUL_EN) begin
              state_d = ST_MUL;
              hi_d    = {WIDTH{1'b0}};
              lo_d    = req_b;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              state_d      = ST_DONE;
              resp_valid_d = 1'b1;
              res_lo_d     = {WIDTH{1'b0}};
              res_hi_d     = {WIDTH{1'b0}};
              res_zero_d   = 1'b0;
              res_ovfl_d   = 1'b0;
              res_err_d    = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_EXEC: begin
          alu_a_s      = a_q;
          alu_b_s      = b_q;
          alu_op_s     = cmd_q;
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          res_lo_d     = alu_r;
          res_hi_d     = {WIDTH{1'b0}};
          res_zero_d   = alu_zero;
          res_ovfl_d   = alu_ovfl;
          res_err_d    = 1'b0;
        end
        ST_MUL: begin
          // ALU forms hi + multiplicand every step; mulstep decides use.
          alu_a_s  = hi_q;
          alu_b_s  = a_q;
          alu_op_s = ALU_ADD;
          hi_d     = step_hi_s;
          lo_d     = step_lo_s;
          cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            res_lo_d     = step_lo_s;
            res_hi_d     = step_hi_s;
            res_zero_d   = ({step_hi_s, step_lo_s} == {(2*WIDTH){1'b0}});
            res_ovfl_d   = (step_hi_s != {WIDTH{1'b0}});
            res_err_d    = 1'b0;
          end else begin
            state_d = ST_MUL;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      endcase
    end

    rdy_d = (state_d == ST_IDLE);
  end

  // State and datapath registers; async reset returns everything to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 3'b000;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      hi_q         <= {WIDTH{1'b0}};
      lo_q         <= {WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      rdy_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      res_lo_q     <= {WIDTH{1'b0}};
      res_hi_q     <= {WIDTH{1'b0}};
      res_zero_q   <= 1'b0;
      res_ovfl_q   <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      rdy_q        <= rdy_d;
      resp_valid_q <= resp_valid_d;
      res_lo_q     <= res_lo_d;
      res_hi_q     <= res_hi_d;
      res_zero_q   <= res_zero_d;
      res_ovfl_q   <= res_ovfl_d;
      res_err_q    <= res_err_d;
    end
  end

  assign alu_a      = alu_a_s;
  assign alu_b      = alu_b_s;
  assign alu_op     = alu_op_s;
  assign resp_valid = resp_valid_q;
  assign res_lo     = res_lo_q;
  assign res_hi     = res_hi_q;
  assign res_zero   = res_zero_q;
  assign res_ovfl   = res_ovfl_q;
  assign res_err    = res_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU16b attached.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_r;
  logic        alu_zero;
  logic        alu_ovfl;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] res_lo;
  logic [15:0] res_hi;
  logic        res_zero;
  logic        res_ovfl;
  logic        res_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int lat;

  alu_seq_ctrl #(
    .WIDTH  (16),
    .MUL_EN (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_r      (alu_r),
    .alu_zero   (alu_zero),
    .alu_ovfl   (alu_ovfl),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .res_zero   (res_zero),
    .res_ovfl   (res_ovfl),
    .res_err    (res_err)
  );

  // Behavioural ALU16b: signed overflow on ADD/SUB, signed SLT.
  always_comb begin
    alu_r    = 16'h0000;
    alu_ovfl = 1'b0;
    case (alu_op)
      3'b000: alu_r = alu_a & alu_b;
      3'b001: alu_r = alu_a | alu_b;
      3'b010: alu_r = ~(alu_a | alu_b);
      3'b011: begin
        alu_r    = alu_a + alu_b;
        alu_ovfl = (alu_a[15] == alu_b[15]) && (alu_r[15] != alu_a[15]);
      end
      3'b100: begin
        alu_r    = alu_a - alu_b;
        alu_ovfl = (alu_a[15] != alu_b[15]) && (alu_r[15] != alu_a[15]);
      end
      3'b101: alu_r = ($signed(alu_a) < $signed(alu_b)) ? 16'h0001 : 16'h0000;
      default: alu_r = 16'h0000;
    endcase
    alu_zero = (alu_r == 16'h0000);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, scramble the request lines, and count edges
  // (accept edge = 0) until resp_valid is seen.
  task automatic send(input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b,
                      output int n);
    check("req_ready_before_send", req_ready, 1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_a     = a;
    req_b     = b;
    tick();
    req_valid = 1'b0;
    req_cmd   = 3'b000;
    req_a     = 16'hA5A5;
    req_b     = 16'h5A5A;
    n = 1;
    while (!resp_valid && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic take();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    check("resp_valid_after_take", resp_valid, 0);
    check("req_ready_after_take", req_ready, 1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_cmd = 3'b000;
    req_a = 16'h0000; req_b = 16'h0000; resp_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_resp_valid", resp_valid, 0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("req_ready_at_release", req_ready, 0);
    tick();
    check("req_ready_after_release", req_ready, 1);

    // ADD overflow
    send(3'b011, 16'h7FFF, 16'h0001, lat);
    check("add_lat", lat, 2);
    check("add_lo", res_lo, 16'h8000);
    check("add_ovfl", res_ovfl, 1);
    check("add_zero", res_zero, 0);
    check("add_hi", res_hi, 0);
    check("add_err", res_err, 0);
    take();

    // SUB to zero
    send(3'b100, 16'h0005, 16'h0005, lat);
    check("sub_lo", res_lo, 16'h0000);
    check("sub_zero", res_zero, 1);
    take();

    // SLT signed
    send(3'b101, 16'hFFFF, 16'h0001, lat);
    check("slt_lo", res_lo, 16'h0001);
    take();

    // NOR and AND
    send(3'b010, 16'h00F0, 16'h0F00, lat);
    check("nor_lo", res_lo, 16'hF00F);
    take();
    send(3'b000, 16'hFF0F, 16'h0FF0, lat);
    check("and_lo", res_lo, 16'h0F00);
    take();

    // MUL max
    send(3'b110, 16'hFFFF, 16'hFFFF, lat);
    check("mul_lat", lat, 17);
    check("mul_hi", res_hi, 16'hFFFE);
    check("mul_lo", res_lo, 16'h0001);
    check("mul_ovfl", res_ovfl, 1);
    check("mul_zero", res_zero, 0);
    take();

    // MUL by zero
    send(3'b110, 16'h1234, 16'h0000, lat);
    check("mul0_lo", res_lo, 16'h0000);
    check("mul0_hi", res_hi, 16'h0000);
    check("mul0_zero", res_zero, 1);
    check("mul0_ovfl", res_ovfl, 0);
    take();

    // MUL crossing into the high half
    send(3'b110, 16'h1234, 16'h0010, lat);
    check("mul16_hi", res_hi, 16'h0001);
    check("mul16_lo", res_lo, 16'h2340);
    check("mul16_ovfl", res_ovfl, 1);
    take();

    // Illegal command with stalled consumer
    send(3'b111, 16'h1111, 16'h2222, lat);
    check("ill_lat", lat, 1);
    check("ill_err", res_err, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ill_hold_valid", resp_valid, 1);
      check("ill_hold_err", res_err, 1);
      check("ill_hold_ready", req_ready, 0);
    end
    take();

    // Flush with req_valid in IDLE: must not be accepted
    flush = 1'b1; req_valid = 1'b1; req_cmd = 3'b011; req_a = 16'h0001; req_b = 16'h0001;
    #1;
    check("flush_idle_ready", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    tick();
    check("flush_idle_not_taken", req_ready, 1);
    check("flush_idle_no_resp", resp_valid, 0);

    // Flush mid-MUL after 8 steps
    req_valid = 1'b1; req_cmd = 3'b110; req_a = 16'h0003; req_b = 16'h0005;
    tick();
    req_valid = 1'b0;
    check("mul_drive_op", alu_op, 3'b011);
    check("mul_drive_b", alu_b, 16'h0003);
    resp_ready = 1'b1;
    repeat (8) tick();
    resp_ready = 1'b0;
    check("mul_ignores_resp_ready", resp_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_mul_ready", req_ready, 1);
    check("flush_mul_alu_op", alu_op, 0);
    check("flush_mul_res_lo", res_lo, 0);
    repeat (20) begin
      tick();
      if (resp_valid) check("flush_mul_no_resp", resp_valid, 0);
    end
    send(3'b011, 16'h0002, 16'h0003, lat);
    check("post_flush_add", res_lo, 16'h0005);
    check("post_flush_lat", lat, 2);
    take();

    // Reset mid-MUL
    req_valid = 1'b1; req_cmd = 3'b110; req_a = 16'hFFFF; req_b = 16'hFFFF;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("rst_mul_alu_a", alu_a, 0);
    check("rst_mul_alu_op", alu_op, 0);
    check("rst_mul_res_lo", res_lo, 0);
    check("rst_mul_req_ready", req_ready, 0);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_mul_ready_release", req_ready, 0);
    tick();
    check("rst_mul_ready_after", req_ready, 1);
    check("rst_mul_resp_valid", resp_valid, 0);
    repeat (20) begin
      tick();
      if (resp_valid) check("rst_mul_no_partial", resp_valid, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
